jtframe_tilerom_bridge: RTL
===========================

// Module: jtframe_tilerom_bridge
// PURPOSE
// Responder side of the tile-ROM read port driven by jtframe tilemap/scroll generators.
// Takes a 32-bit pixel-plane fetch (rom_cs/rom_addr) and serves it from 16-bit SDRAM:
// two-beat read, both halves assembled into one word, rom_ok/rom_data returned.
// Holds a one-entry tag so repeated requests to the same address cost no SDRAM access.
// Sits between the tilemap and one SDRAM bank slot in the core's memory arbiter.
// PARAMETERS
// AW      15          rom_addr width (32-bit word address)
// SW      22          sdram_addr width (16-bit word address)
// OFFSET  0           SW-bit base added to every SDRAM address (region start)
// SWAP    0           1: first SDRAM beat goes to rom_data[31:16] instead of [15:0]
// PORTS
// rst         in   1     asynchronous reset, active-high
// clk         in   1     system clock
// rom_cs      in   1     request valid; level, held by requester
// rom_addr    in   AW    32-bit word address
// rom_data    out  32    assembled data for the tag address
// rom_ok      out  1     rom_cs & tag_valid & (rom_addr==tag); combinational compare on registered tag
// sdram_addr  out  SW    OFFSET + {rom_addr_latched,1'b0}
// sdram_req   out  1     read request; held until sdram_gnt
// sdram_gnt   in   1     arbiter accepted the request (single-cycle pulse)
// sdram_dst   in   1     data strobe; one pulse per 16-bit beat
// sdram_din   in   16    SDRAM read data, valid with sdram_dst
// BEHAVIOUR
// Reset: rom_data=0, tag=0, tag_valid=0, sdram_req=0, sdram_addr=OFFSET, state=IDLE; rom_ok=0.
// Reset mid-fetch aborts at once; beats that arrive later are ignored because state is IDLE.
// FSM IDLE -> REQ -> BEAT0 -> BEAT1 -> IDLE.
//  IDLE : on rom_cs & !hit: latch addr, drive sdram_addr, sdram_req<=1, go to REQ.
//         hit = tag_valid & rom_addr==tag.
//  REQ  : hold sdram_req/sdram_addr; on sdram_gnt: sdram_req<=0, go to BEAT0.
//  BEAT0: on sdram_dst: capture sdram_din in the low half (high half if SWAP), go to BEAT1.
//  BEAT1: on sdram_dst: write the full 32-bit word to rom_data; tag<=latched addr;
//         tag_valid<=1; go to IDLE.
// rom_data and tag change only at the end of BEAT1 (atomic), never during a burst.
// Latency from a miss in IDLE to rom_ok=1, with gnt on its first possible cycle:
// 1 (req registered) + gnt wait + beat waits + 1 (tag update).
// Boundary cases:
//  - addr change mid-burst: burst completes for the latched addr; tag is written; the
//    next IDLE cycle sees a miss and starts a new fetch. No abort, no merge.
//  - rom_cs dropped mid-burst: burst still completes and tag updates. SDRAM cannot abort.
//  - gnt and dst in the same cycle while in REQ: that dst is ignored. The arbiter never does this.
//  - dst while in IDLE or REQ: ignored.
//  - rom_cs low: no new request; rom_ok=0; rom_data holds its value.
//  - sdram_addr arithmetic is SW bits, modulo 2^SW; overflow wraps silently.
// STRUCTURE
// Single module, no sub-module. State encoding uses local localparams.
// SDRAM data width (16) and burst length (2) come from the shared jtframe SDRAM defines
// header, so arbiter and bridges agree.
// TESTING
// 1 rst high mid-REQ -> sdram_req=0 next clk; rom_ok=0; rom_data=0; later dst pulses ignored.
// 2 rom_cs=1 addr=0x0123 OFFSET=0x10000; gnt after 3 clk; din 0xBEEF then 0xDEAD
//   -> sdram_addr=0x10246; rom_data=0xDEADBEEF; rom_ok=1.
// 3 repeat addr 0x0123 -> rom_ok=1 same cycle; sdram_req stays 0.
// 4 SWAP=1 with the same beats -> rom_data=0xBEEFDEAD.
// 5 addr 0x0200 -> 0x0201 during BEAT0 -> first burst sets tag=0x0200; then second req
//   with sdram_addr=OFFSET+0x402; rom_ok=0 until it completes.
// 6 rom_cs dropped in BEAT0 -> burst finishes; later rom_cs with same addr -> immediate rom_ok.

Source files
------------

// File: rtl/jtframe_tilerom_bridge_pkg.sv
// Shared definitions for the tile-ROM bridge: SDRAM beat geometry and FSM states.
// The beat width and burst length match the arbiter's SDRAM slot layout.
package jtframe_tilerom_bridge_pkg;

  localparam int SDRAM_DW  = 16;
  localparam int BURST_LEN = 2;
  localparam int ROM_DW    = SDRAM_DW * BURST_LEN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_BEAT0 = 2'd2,
    ST_BEAT1 = 2'd3
  } state_t;

endpackage

// File: rtl/jtframe_tilerom_bridge.sv
// Serves 32-bit tilemap ROM fetches from a 16-bit SDRAM slot with a two-beat read.
// A one-entry tag lets repeated requests to the same address complete without SDRAM traffic.
module jtframe_tilerom_bridge
  import jtframe_tilerom_bridge_pkg::*;
#(
  parameter int            AW     = 15,
  parameter int            SW     = 22,
  parameter logic [SW-1:0] OFFSET = '0,
  parameter bit            SWAP   = 1'b0
) (
  input  logic              rst,
  input  logic              clk,
  input  logic              rom_cs,
  input  logic [AW-1:0]     rom_addr,
  output logic [ROM_DW-1:0] rom_data,
  output logic              rom_ok,
  output logic [SW-1:0]     sdram_addr,
  output logic              sdram_req,
  input  logic              sdram_gnt,
  input  logic              sdram_dst,
  input  logic [SDRAM_DW-1:0] sdram_din
);

  state_t              state;
  state_t              state_nxt;
  logic [AW-1:0]       addr_lat;
  logic [AW-1:0]       tag;
  logic                tag_valid;
  logic [SDRAM_DW-1:0] beat0;
  logic                hit;
  logic                start;
  logic                granted;
  logic                take0;
  logic                take1;

  // Region base plus 16-bit word address; wraps modulo 2^SW.
  function automatic logic [SW-1:0] sdram_word(input logic [AW-1:0] a);
    return OFFSET + SW'({a, 1'b0});
  endfunction

  function automatic logic [ROM_DW-1:0] assemble(input logic [SDRAM_DW-1:0] first,
                                                 input logic [SDRAM_DW-1:0] second);
    return SWAP ? {first, second} : {second, first};
  endfunction

  assign hit    = tag_valid && (rom_addr == tag);
  assign rom_ok = rom_cs && hit;

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    granted   = 1'b0;
    take0     = 1'b0;
    take1     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rom_cs && !hit) begin
          start     = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      // A strobe coinciding with the grant is not a beat of this burst.
      ST_REQ: begin
        if (sdram_gnt) begin
          granted   = 1'b1;
          state_nxt = ST_BEAT0;
        end
      end
      ST_BEAT0: begin
        if (sdram_dst) begin
          take0     = 1'b1;
          state_nxt = ST_BEAT1;
        end
      end
      ST_BEAT1: begin
        if (sdram_dst) begin
          take1     = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // rom_data and tag move together at the last beat so a reader never sees a half-updated word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_data   <= '0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      sdram_req  <= 1'b0;
      sdram_addr <= OFFSET;
    end else begin
      if (start) begin
        sdram_addr <= sdram_word(rom_addr);
        sdram_req  <= 1'b1;
      end
      if (granted) sdram_req <= 1'b0;
      if (take1) begin
        rom_data  <= assemble(beat0, sdram_din);
        tag       <= addr_lat;
        tag_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) addr_lat <= rom_addr;
    if (take0) beat0    <= sdram_din;
  end

endmodule
